display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit 7-segment display driven by the counter datapath. It latches a 16-bit hex/BCD value once per frame and decodes one digit at a time. Each digit slot is sequenced with a dead-time before the segments are shown, which prevents ghosting. It drives the segment bus and the one-hot digit-select bus that go to the chip's dedicated and bidirectional output pins.

Parameters:
PRESCALE, 1024, clock cycles per digit slot (>= 4)
BLANK_CYC, 16, dead-time cycles at start of each slot; must satisfy 1 <= BLANK_CYC < PRESCALE
SEG_ACTIVE_LOW, 0, 1 = invert seg_out (common-anode panels)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; low = display dark, scan held at start
digits_in  input  16  four nibbles; [3:0] = digit 0 (rightmost) .. [15:12] = digit 3
dp_in  input  4  decimal point per digit, bit i = digit i
lz_blank  input  1  1 = suppress leading zeros
seg_out  output  8  [6:0] = segments g..a, [7] = dp; active-high unless SEG_ACTIVE_LOW
sel_out  output  4  one-hot digit select, active-high, bit i = digit i
frame_done  output  1  one-cycle pulse at end of each full 4-digit frame

Behaviour:
- Single clock domain. rst is sampled on the clk edge only and has priority over en.
- All outputs are registered.
- Reset and en=0 both produce the same state:
  - state IDLE, slot counter cnt=0, digit index idx=0
  - sel_out=0000, frame_done=0
  - seg_out = "off": 0x00, or 0xFF when SEG_ACTIVE_LOW=1
- States: IDLE, BLANK, SHOW.
  - IDLE -> BLANK when en=1. On this transition digits_in, dp_in and lz_blank are snapshotted; idx=0, cnt=0.
  - BLANK: sel_out=0, seg off. cnt increments. At cnt=BLANK_CYC-1 -> SHOW.
  - SHOW: sel_out = one-hot(idx), seg_out = decode(snapshot nibble idx).
    - cnt increments. At cnt=PRESCALE-1: cnt=0, idx=idx+1 mod 4, -> BLANK.
    - Wrapping 3->0 takes a new snapshot and pulses frame_done for exactly one cycle, coinciding with the first BLANK cycle of the new frame.
- Slot timing: BLANK_CYC cycles dark, then PRESCALE-BLANK_CYC cycles lit. Frame = 4*PRESCALE cycles. Output registers add 1 cycle of latency after state entry.
- en falling at any point, including mid-slot: the next cycle is IDLE with outputs off and no frame_done. Re-enable restarts at digit 0 with a full BLANK.
- Decode (active-high, dp excluded):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - seg_out[7] = snapshot dp bit. SEG_ACTIVE_LOW inverts all 8 bits.
- Leading-zero blanking (snapshot lz_blank=1):
  - Digit i (i = 3, 2, 1) is blanked when nibble i = 0 and all higher nibbles are 0. Digit 0 is never blanked.
  - A blanked digit still gets its sel_out slot. Its segments are off, except seg[7], which still follows dp.
- The snapshot removes tearing: changes to digits_in mid-frame are invisible until the next frame starts.

Test Plan:
(PRESCALE=8, BLANK_CYC=2, SEG_ACTIVE_LOW=0 unless noted)
1. Reset: rst=1 for 5 cycles with en=1, digits_in=0x8888.
   - Required: seg_out=0x00, sel_out=0000, frame_done=0 throughout.
   - After rst drops: 2 dark cycles, then sel_out=0001.
2. Scan order: digits_in=0x1234, en=1.
   - Required: sel_out sequence 0001/0010/0100/1000, each lit 6 cycles after 2 dark cycles.
   - seg_out per digit = 0x66, 0x4F, 0x5B, 0x06.
   - frame_done pulses every 32 cycles.
3. Snapshot: change digits_in 0x1234 -> 0x5678 while digit 1 is lit.
   - Required: digits 2 and 3 still show 0x5B and 0x06.
   - The next frame shows 0x7F, 0x07, 0x7D, 0x6D.
4. Leading zeros: lz_blank=1.
   - digits_in=0x0050: digits 3 and 2 show 0x00 with sel still asserted; digit 1 = 0x6D; digit 0 = 0x3F.
   - digits_in=0x0000: only digit 0 lit, 0x3F.
   - digits_in=0x0500: digit 1 shows 0x3F, not blanked.
5. Hex, dp and polarity: digits_in=0x000A, dp_in=0001, lz_blank=0.
   - Required: digit 0 = 0xF7.
   - With SEG_ACTIVE_LOW=1: digit 0 = 0x08, and the off value = 0xFF.
6. Mid-frame abort: drop en while digit 2 is lit.
   - Required: next cycle sel_out=0000 and seg off, no frame_done.
   - On re-enable: 2 dark cycles, then digit 0.
   - Repeat using rst instead of en; same result.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Latches a 16-bit value once per frame and shows one digit per slot after a dead-time.
module display_scan_ctrl #(
  parameter int unsigned PRESCALE       = 1024,
  parameter int unsigned BLANK_CYC      = 16,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [7:0]  seg_out,
  output logic [3:0]  sel_out,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_digits_q, snap_digits_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic          snap_lz_q, snap_lz_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    sel_q, sel_d;
  logic          frame_done_q, frame_done_d;

  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          lz_hide;
  logic [7:0]    seg_raw;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;
      4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;
      4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;
      4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;
      4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;
      4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;
      default: decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_lz_d     = snap_lz_q;
    frame_done_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = BLANK;
          cnt_d         = '0;
          idx_d         = 2'd0;
          snap_digits_d = digits_in;
          snap_dp_d     = dp_in;
          snap_lz_d     = lz_blank;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            state_d = BLANK;
            // A new frame starts on the 3->0 wrap: resample inputs to avoid tearing.
            if (idx_q == 2'd3) begin
              snap_digits_d = digits_in;
              snap_dp_d     = dp_in;
              snap_lz_d     = lz_blank;
              frame_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // SHOW is always entered from BLANK, so the snapshot registers are already settled here.
  always_comb begin
    nibble  = snap_digits_q[{idx_d, 2'b00} +: 4];
    glyph   = decode(nibble);
    lz_hide = snap_lz_q && (idx_d != 2'd0) &&
              ((snap_digits_q >> {idx_d, 2'b00}) == 16'd0);
    seg_raw = {snap_dp_q[idx_d], lz_hide ? 7'h00 : glyph};
    seg_d   = SEG_OFF;
    sel_d   = 4'b0000;
    if (state_d == SHOW) begin
      sel_d = 4'b0001 << idx_d;
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= 2'd0;
      snap_digits_q <= 16'h0000;
      snap_dp_q     <= 4'h0;
      snap_lz_q     <= 1'b0;
      seg_q         <= SEG_OFF;
      sel_q         <= 4'b0000;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_lz_q     <= snap_lz_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign sel_out    = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: an active-high and an active-low instance share
// the same stimulus (PRESCALE=8, BLANK_CYC=2) and are checked every cycle.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        lz_blank;

  logic [7:0]  seg_hi, seg_lo;
  logic [3:0]  sel_hi, sel_lo;
  logic        fd_hi, fd_lo;

  int vectors     = 0;
  int miscompares = 0;

  logic [25:0] act;
  logic [25:0] exp_v;

  localparam logic [25:0] OFF_V = {2'b00, 4'b0000, 4'b0000, 8'h00, 8'hFF};

  display_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg_out(seg_hi), .sel_out(sel_hi), .frame_done(fd_hi)
  );

  display_scan_ctrl #(.PRESCALE(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .lz_blank(lz_blank), .seg_out(seg_lo), .sel_out(sel_lo), .frame_done(fd_lo)
  );

  always #5 clk = ~clk;

  assign act = {fd_hi, fd_lo, sel_hi, sel_lo, seg_hi, seg_lo};

  // Expected outputs c cycles after the scan starts; segs holds active-high digit 3..0.
  function automatic logic [25:0] model(input int c, input logic [31:0] segs);
    int         slot;
    int         ph;
    logic       fd;
    logic [3:0] sel;
    logic [7:0] s;
    logic [7:0] s_lo;
    slot = (c / 8) % 4;
    ph   = c % 8;
    fd   = (c != 0) && (c % 32 == 0);
    if (ph < 2) begin
      sel  = 4'b0000;
      s    = 8'h00;
      s_lo = 8'hFF;
    end else begin
      sel  = 4'b0001 << slot;
      s    = segs[slot*8 +: 8];
      s_lo = ~s;
    end
    return {fd, fd, sel, sel, s, s_lo};
  endfunction

  // Load inputs and pulse reset for one cycle; the next negedge is scan cycle 0.
  task automatic start(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    @(negedge clk);
    digits_in = d;
    dp_in     = dp;
    lz_blank  = lz;
    en        = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    en        = 1'b1;
    digits_in = 16'h8888;
    dp_in     = 4'h0;
    lz_blank  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (act !== OFF_V) begin
        miscompares++;
        $display("[TB] FAIL reset i=%0d act=%h exp=%h", i, act, OFF_V);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp_v = model(c, 32'h7F7F7F7F);
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL reset_release c=%0d act=%h exp=%h", c, act, exp_v);
      end
    end
  endtask

  task automatic test_scan_order();
    start(16'h1234, 4'h0, 1'b0);
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      exp_v = model(c, {8'h06, 8'h5B, 8'h4F, 8'h66});
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL scan_order c=%0d act=%h exp=%h", c, act, exp_v);
      end
    end
  endtask

  task automatic test_snapshot();
    start(16'h1234, 4'h0, 1'b0);
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      exp_v = model(c, (c < 32) ? {8'h06, 8'h5B, 8'h4F, 8'h66}
                                : {8'h6D, 8'h7D, 8'h07, 8'h7F});
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL snapshot c=%0d act=%h exp=%h", c, act, exp_v);
      end
      if (c == 11) digits_in = 16'h5678;
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] vals [3];
    logic [31:0] segs [3];
    vals[0] = 16'h0050; segs[0] = {8'h00, 8'h00, 8'h6D, 8'h3F};
    vals[1] = 16'h0000; segs[1] = {8'h00, 8'h00, 8'h00, 8'h3F};
    vals[2] = 16'h0500; segs[2] = {8'h00, 8'h6D, 8'h3F, 8'h3F};
    for (int v = 0; v < 3; v++) begin
      start(vals[v], 4'h0, 1'b1);
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        exp_v = model(c, segs[v]);
        vectors++;
        if (act !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL leading_zeros val=%h c=%0d act=%h exp=%h", vals[v], c, act, exp_v);
        end
      end
    end
  endtask

  task automatic test_hex_dp();
    logic [15:0] vals [3];
    logic [3:0]  dps  [3];
    logic [31:0] segs [3];
    vals[0] = 16'h000A; dps[0] = 4'b0001; segs[0] = {8'h3F, 8'h3F, 8'h3F, 8'hF7};
    vals[1] = 16'hFEDC; dps[1] = 4'b1010; segs[1] = {8'hF1, 8'h79, 8'hDE, 8'h39};
    vals[2] = 16'h9B00; dps[2] = 4'b0000; segs[2] = {8'h6F, 8'h7C, 8'h3F, 8'h3F};
    for (int v = 0; v < 3; v++) begin
      start(vals[v], dps[v], 1'b0);
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        exp_v = model(c, segs[v]);
        vectors++;
        if (act !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL hex_dp val=%h c=%0d act=%h exp=%h", vals[v], c, act, exp_v);
        end
      end
    end
  endtask

  task automatic test_abort();
    for (int mode = 0; mode < 2; mode++) begin
      start(16'h1234, 4'h0, 1'b0);
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        exp_v = model(c, {8'h06, 8'h5B, 8'h4F, 8'h66});
        vectors++;
        if (act !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL abort_pre mode=%0d c=%0d act=%h exp=%h", mode, c, act, exp_v);
        end
      end
      if (mode == 0) en = 1'b0;
      else           rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        vectors++;
        if (act !== OFF_V) begin
          miscompares++;
          $display("[TB] FAIL abort_off mode=%0d k=%0d act=%h exp=%h", mode, k, act, OFF_V);
        end
      end
      en  = 1'b1;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        exp_v = model(c, {8'h06, 8'h5B, 8'h4F, 8'h66});
        vectors++;
        if (act !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL abort_restart mode=%0d c=%0d act=%h exp=%h", mode, c, act, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_snapshot();
    test_leading_zeros();
    test_hex_dp();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
